// File: rtl/trace_capture_ctrl_if.sv
// trace_capture_ctrl_if: replay stream from the trace buffer to the debug readout
interface trace_capture_ctrl_if #(parameter int DATA_W = 96);
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  modport master(output rd_valid, rd_data, rd_last, input rd_ready);
  modport slave(input rd_valid, rd_data, rd_last, output rd_ready);
endinterface

// File: rtl/trace_capture_ctrl.sv
// trace_capture_ctrl: circular trace buffer with trigger, post-trigger capture and oldest-first replay
module trace_capture_ctrl #(
  parameter int DATA_W = 96,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_arm,
  input  logic [ADDR_W-1:0]    cfg_post,
  input  logic                 cfg_edge,
  input  logic                 trig_i,
  input  logic                 sample_valid,
  input  logic [DATA_W-1:0]    data_i,
  input  logic                 rd_start,
  trace_capture_ctrl_if.master rd,
  output logic [2:0]           state_o,
  output logic [ADDR_W-1:0]    trig_addr,
  output logic [ADDR_W:0]      fill_cnt
);
  typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, POST = 3'd2, DONE = 3'd3, READ = 3'd4} state_t;
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
  localparam logic [ADDR_W:0]   ONE_F = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   FULL  = (ADDR_W+1)'(DEPTH);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] post_q, post_d, post_cfg_q, post_cfg_d;
  logic [ADDR_W:0]   fill_q, fill_d, rem_q, rem_d;
  logic edge_q, edge_d, trig_q, trig_d, rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic wr_en, hit, accept, post_end, rd_hs, load, read_go;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  // next-state: arm overrides everything, then trigger, post countdown, readout start/finish
  always_comb begin
    state_d = cfg_arm                                 ? ARMED :
              accept                                  ? (post_cfg_q == '0 ? DONE : POST) :
              post_end                                ? DONE :
              read_go                                 ? READ :
              (state_q == READ && rd_hs && rd_last_q) ? DONE : state_q;
  end
  // FSM-derived strobes: sample writes, trigger acceptance, readout prefetch
  always_comb begin
    wr_en    = (state_q == ARMED || state_q == POST) && sample_valid && !cfg_arm;
    hit      = edge_q ? (trig_i & ~trig_q) : trig_i;
    accept   = state_q == ARMED && wr_en && hit;
    post_end = state_q == POST && wr_en && post_q == ONE_A;
    rd_hs    = rd_valid_q & rd.rd_ready;
    load     = state_q == READ && rem_q != '0 && (!rd_valid_q || rd.rd_ready);
    read_go  = state_q == DONE && rd_start && !cfg_arm;
  end
  // datapath next values: pointers, counters, latched config, replay output stage
  always_comb begin
    wr_ptr_d    = cfg_arm ? '0 : wr_en ? wr_ptr_q + ONE_A : wr_ptr_q;
    fill_d      = cfg_arm ? '0 : (wr_en && fill_q != FULL) ? fill_q + ONE_F : fill_q;
    trig_addr_d = accept ? wr_ptr_q : trig_addr_q;
    post_cfg_d  = cfg_arm ? cfg_post : post_cfg_q;
    edge_d      = cfg_arm ? cfg_edge : edge_q;
    trig_d      = cfg_arm ? 1'b0 : trig_i;
    post_d      = accept ? post_cfg_q : (state_q == POST && wr_en) ? post_q - ONE_A : post_q;
    rd_ptr_d    = read_go ? wr_ptr_q - fill_q[ADDR_W-1:0] : load ? rd_ptr_q + ONE_A : rd_ptr_q;
    rem_d       = cfg_arm ? '0 : read_go ? fill_q : load ? rem_q - ONE_F : rem_q;
    rd_valid_d  = cfg_arm ? 1'b0 : load ? 1'b1 : rd_hs ? 1'b0 : rd_valid_q;
    rd_last_d   = cfg_arm ? 1'b0 : load ? (rem_q == ONE_F) : rd_hs ? 1'b0 : rd_last_q;
  end
  // datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      trig_addr_q <= '0;
      post_cfg_q  <= '0;
      edge_q      <= 1'b0;
      trig_q      <= 1'b0;
      post_q      <= '0;
      rd_ptr_q    <= '0;
      rem_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      trig_addr_q <= trig_addr_d;
      post_cfg_q  <= post_cfg_d;
      edge_q      <= edge_d;
      trig_q      <= trig_d;
      post_q      <= post_d;
      rd_ptr_q    <= rd_ptr_d;
      rem_q       <= rem_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
    end
  // sample RAM: write port for capture, registered read port doubles as the output holding stage
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= data_i;
    if (load)  ram_q <= mem[rd_ptr_q];
  end
  // outputs; rd_data is masked so it reads zero whenever no word is presented
  always_comb begin
    state_o     = state_q;
    trig_addr   = trig_addr_q;
    fill_cnt    = fill_q;
    rd.rd_valid = rd_valid_q;
    rd.rd_last  = rd_last_q;
    rd.rd_data  = rd_valid_q ? ram_q : '0;
  end
endmodule

// File: doc/trace_capture_ctrl.md
Name: trace_capture_ctrl

Overview:
Sequencer for the on-chip debug trace of the core's fetch/decode datapath. Each sample is a DATA_W-bit word {inst, pc_out, imm}. The block records samples into an internal circular buffer and, once triggered, captures a programmed number of post-trigger samples. It then replays the buffer oldest-first over a valid/ready stream to the debug readout logic. It sits beside core_u and is fed the same probe nets as the logic-analyzer core.

Parameters:
DATA_W, 96, sample width ({inst[31:0], pc_out[31:0], imm[31:0]}, MSB first)
DEPTH, 256, buffer entries; power of two, >=4
ADDR_W, 8, log2(DEPTH)

Ports:
clk  in  1  capture/read clock
rst  in  1  asynchronous reset, active-high
cfg_arm  in  1  single-cycle pulse: (re)start a capture
cfg_post  in  ADDR_W  post-trigger sample count, latched on cfg_arm
cfg_edge  in  1  trigger mode, latched on cfg_arm: 0 = level-high, 1 = rising edge
trig_i  in  1  trigger source
sample_valid  in  1  data_i is a valid sample this cycle
data_i  in  DATA_W  sample word
rd_start  in  1  pulse: begin readout (honoured only in DONE)
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts rd_data
rd_data  out  DATA_W  replayed sample
rd_last  out  1  qualifies the final word of the replay
state_o  out  3  IDLE=0, ARMED=1, POST=2, DONE=3, READ=4
trig_addr  out  ADDR_W  buffer index of the trigger sample
fill_cnt  out  ADDR_W+1  valid entries in buffer (saturates at DEPTH)

Behaviour:
- Reset (async): state IDLE; wr_ptr=0; fill_cnt=0; trig_addr=0; rd_valid=0; rd_last=0; rd_data=0; trigger edge history=0.
- Write rule: in ARMED and POST, every cycle with sample_valid=1:
  - write buf[wr_ptr]=data_i, then wr_ptr+1 mod DEPTH;
  - fill_cnt+1, saturating at DEPTH.
- IDLE: no writes. cfg_arm -> ARMED.
- cfg_arm in any state (including READ):
  - next state ARMED; wr_ptr=0, fill_cnt=0, rd_valid=0;
  - latch cfg_post (values >DEPTH-1 impossible by width) and cfg_edge;
  - edge history cleared to 0.
- Trigger detect:
  - hit = trig_i when edge mode is 0;
  - hit = trig_i & ~trig_q when edge mode is 1, where trig_q is trig_i registered every cycle.
  - A trigger is accepted only in ARMED on a cycle with sample_valid=1 and hit=1. Hit without sample_valid is lost.
- ARMED -> on accepted trigger:
  - the trigger sample is written; trig_addr=wr_ptr (pre-increment);
  - post counter = latched cfg_post;
  - if cfg_post=0: DONE; else POST.
- POST: each sample_valid write decrements the post counter. The write that takes it 1->0 moves the block to DONE in the same cycle. Trigger ignored.
- DONE: no writes; buffer frozen. rd_start -> READ.
- Read start pointer:
  - rd_ptr = wr_ptr-fill_cnt mod DEPTH, i.e. 0 if not wrapped, wr_ptr if wrapped;
  - remaining = fill_cnt.
- READ pipeline:
  - synchronous RAM read, 1-cycle latency; rd_valid first rises 2 cycles after the rd_start cycle;
  - rd_data/rd_valid held stable while rd_valid & ~rd_ready;
  - on handshake, next word is presented in the following cycle (full throughput with 1-entry prefetch, no bubbles when rd_ready held high);
  - rd_last=1 with the fill_cnt-th word;
  - handshake on the last word -> rd_valid=0, state DONE. The buffer is still intact and may be replayed by another rd_start.
- Boundaries:
  - fill_cnt saturates; once wrapped, the oldest entries are overwritten;
  - trigger on the very first sample gives trig_addr=0;
  - rd_start outside DONE is ignored;
  - rst mid-READ aborts immediately, all outputs return to reset values.
- trig_addr and fill_cnt remain valid in DONE/READ until the next cfg_arm or rst.

Test Plan:
1. rst, cfg_arm with post=3 level mode; 10 samples 0..9 with trig_i high on sample 5 -> trig_addr=5, DONE after sample 8, fill_cnt=9, sample 9 not written.
2. Then rd_start with rd_ready=1 -> rd_valid first rises 2 cycles later; words 0..8 on consecutive cycles; rd_last on word 8; state DONE.
3. DEPTH=256, post=10; 300 samples before trigger on sample 300 -> fill_cnt=256; replay starts at sample 55, ends at sample 310 with rd_last.
4. Edge mode, trig_i held high from arm -> no trigger; fall then rise with sample_valid -> trigger on rising sample only; post=0 -> DONE the same cycle.
5. Randomly toggled rd_ready during replay -> rd_data stable while stalled, no word dropped or duplicated, order matches the written sequence.
6. cfg_arm mid-POST -> ARMED with fill_cnt=0; async rst mid-READ -> rd_valid=0 and state IDLE within the reset assertion, no clock needed.
